// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: signed feature element, per-pixel channel vector,
// and the signed max helper used by the pooling stages.
package cnn_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int NUM_CHANNELS = 6;

  typedef logic signed [DATA_WIDTH-1:0] feature_t;
  typedef feature_t [0:NUM_CHANNELS-1]  feature_vec_t;

  // Two's-complement max; on a tie both operands are equal so either is fine.
  function automatic feature_t smax(input feature_t a, input feature_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Distributed-RAM line buffer: synchronous write, asynchronous read.
// Contents are never reset; every entry is written before it is read.
module pool_line_buffer #(
  parameter int DEPTH  = 20,
  parameter int WIDTH  = 48,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 per-channel max pooling with optional ReLU over a raster-ordered
// conv feature stream. Even rows park their column-pair maxima in a line buffer.
module max_pool_2x2
  import cnn_pkg::*;
#(
  parameter int IN_COLS = 41,
  parameter int IN_ROWS = 25,
  parameter bit RELU_EN = 1'b1
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_feature_valid,
  input  feature_t i_features [0:NUM_CHANNELS-1],
  output logic     o_feature_valid,
  output feature_t o_features [0:NUM_CHANNELS-1],
  output logic     o_frame_done
);

  // Stream protocol: valid-only. An input vector is consumed on every cycle
  // i_feature_valid is high; o_feature_valid and o_frame_done are one-cycle
  // beats. There is no ready in either direction.

  localparam int POOL_COLS = IN_COLS / 2;
  localparam int ACT_COLS  = 2 * POOL_COLS;
  localparam int ACT_ROWS  = 2 * (IN_ROWS / 2);
  localparam int COL_W     = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
  localparam int ROW_W     = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam int ADDR_W    = (POOL_COLS > 1) ? $clog2(POOL_COLS) : 1;
  localparam int VEC_W     = $bits(feature_vec_t);

  logic [COL_W-1:0]  col_ctr;
  logic [ROW_W-1:0]  row_ctr;
  logic              col_last;
  logic              row_last;
  logic              in_active;
  logic              odd_col;
  logic              odd_row;
  logic              lb_wr_en;
  logic [ADDR_W-1:0] lb_addr;

  feature_t     hold_q [0:NUM_CHANNELS-1];
  feature_t     pair   [0:NUM_CHANNELS-1];
  feature_t     res    [0:NUM_CHANNELS-1];
  feature_vec_t wr_vec;
  feature_vec_t rd_vec;

  assign col_last  = (col_ctr == COL_W'(IN_COLS - 1));
  assign row_last  = (row_ctr == ROW_W'(IN_ROWS - 1));
  assign odd_col   = col_ctr[0];
  assign odd_row   = row_ctr[0];
  // A trailing odd column/row has no partner and is skipped.
  assign in_active = (int'(col_ctr) < ACT_COLS) && (int'(row_ctr) < ACT_ROWS);
  assign lb_addr   = ADDR_W'(col_ctr >> 1);
  assign lb_wr_en  = i_feature_valid && in_active && odd_col && !odd_row;

  always_comb begin
    wr_vec = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      pair[c]   = smax(hold_q[c], i_features[c]);
      res[c]    = smax(feature_t'(rd_vec[c]), pair[c]);
      if (RELU_EN && res[c][DATA_WIDTH-1]) begin
        res[c] = '0;
      end
      wr_vec[c] = pair[c];
    end
  end

  pool_line_buffer #(
    .DEPTH  (POOL_COLS),
    .WIDTH  (VEC_W),
    .ADDR_W (ADDR_W)
  ) u_line_buffer (
    .clk     (i_clk),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (wr_vec),
    .rd_addr (lb_addr),
    .rd_data (rd_vec)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_ctr         <= '0;
      row_ctr         <= '0;
      hold_q          <= '{default: '0};
      o_feature_valid <= 1'b0;
      o_features      <= '{default: '0};
      o_frame_done    <= 1'b0;
    end else begin
      o_feature_valid <= 1'b0;
      o_frame_done    <= 1'b0;
      if (i_feature_valid) begin
        if (col_last) begin
          col_ctr <= '0;
          row_ctr <= row_last ? '0 : row_ctr + ROW_W'(1);
        end else begin
          col_ctr <= col_ctr + COL_W'(1);
        end
        o_frame_done <= col_last && row_last;
        if (in_active) begin
          if (!odd_col) begin
            hold_q <= i_features;
          end else if (odd_row) begin
            o_features      <= res;
            o_feature_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/max_pool_2x2.md
Name: max_pool_2x2

Overview:
- Pooling stage directly downstream of the 5x5 convolution block.
- Consumes the conv block's 6-channel signed 8-bit feature stream in raster order.
- Performs 2x2 stride-2 max pooling per channel, with optional ReLU, and emits the pooled 6-channel stream to the next layer.
- Accepts one input vector per cycle with no backpressure, because the conv block has no ready input.

Parameters:
- NUM_CHANNELS, 6, feature maps per input vector
- DATA_WIDTH, 8, signed feature width
- IN_COLS, 41, conv output columns per row (45-4)
- IN_ROWS, 25, conv output rows per frame (29-4)
- RELU_EN, 1, 1 = clamp negative pooled results to 0

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_feature_valid  in  1  i_features valid this cycle
- i_features  in  NUM_CHANNELS x DATA_WIDTH (signed, unpacked [0:5])  conv output vector
- o_feature_valid  out  1  o_features valid this cycle
- o_features  out  NUM_CHANNELS x DATA_WIDTH (signed, unpacked [0:5])  pooled vector
- o_frame_done  out  1  one-cycle pulse after last input of a frame

Behaviour:
- Clock and reset: single clock i_clk; i_rst is asynchronous, active-high.
- Reset values: o_feature_valid=0, o_features all 0, o_frame_done=0, col_ctr=0, row_ctr=0, hold regs 0. Line-buffer contents are not reset; they are always written before being read.
- Counters advance only on i_feature_valid.
  - col_ctr counts 0..IN_COLS-1, then wraps to 0 and increments row_ctr.
  - row_ctr counts 0..IN_ROWS-1, then wraps to 0.
- Idle cycles (valid low) do not change any state except clearing the output pulses.
- Active region: col < 2*(IN_COLS/2) (=40) and row < 2*(IN_ROWS/2) (=24).
  - Inputs outside it (col 40, row 24) advance counters only. They never affect outputs.
- Even col, active: hold[c] <= i_features[c].
- Odd col, active: pair[c] = signed max(hold[c], i_features[c]).
  - Even row: line_buf[col>>1][c] <= pair[c].
  - Odd row: res[c] = signed max(line_buf[col>>1][c], pair[c]).
  - If RELU_EN and res<0, res=0. Register res to o_features and assert o_feature_valid for exactly 1 cycle.
- Latency: output is registered 1 cycle after the accepted odd-row, odd-col input.
- o_features holds its last value while o_feature_valid=0.
- Output count: (IN_COLS/2)*(IN_ROWS/2) = 20*12 = 240 vectors per frame.
  - Order is raster over the pooled grid (prow 0..11, pcol 0..19).
- o_frame_done: asserted 1 cycle after the input at (row IN_ROWS-1, col IN_COLS-1) is accepted. Counters are at 0 for the next frame in that cycle.
- Back-to-back frames: no gap required. The first input of the next frame may arrive in the cycle o_frame_done is high.
- Comparisons are strictly signed two's complement.
  - Ties are allowed to pick either operand (values are identical).
  - No width growth; results are DATA_WIDTH.
- Reset mid-frame: all counters return to 0 immediately and any pending output is dropped. The next valid input is treated as (row 0, col 0).
- Line buffer: IN_COLS/2 entries of NUM_CHANNELS*DATA_WIDTH bits; combinational read, synchronous write. Read and write never target the same row parity in one cycle, so no bypass is needed.

Decomposition:
- Shared package cnn_pkg:
  - DATA_WIDTH and NUM_CHANNELS constants
  - typedef feature_t (logic signed [DATA_WIDTH-1:0])
  - typedef feature_vec_t (feature_t [0:NUM_CHANNELS-1])
  - function smax(a,b) returning the signed max
- One sub-module: pool_line_buffer, a parameterised depth/width distributed RAM with write enable, write address, read address and asynchronous read.
- Counters, hold regs, compare and ReLU stay in max_pool_2x2.

Test Plan:
- Single peak: all inputs -5 except ch2=+100 at (row 3, col 6), RELU_EN=1 -> pooled (1,3) ch2=100; every other output 0; exactly 240 outputs.
- Column ramp: input value = col (0..40), all rows and channels -> pooled pcol k = 2k+1 for k=0..19 on every prow; value 40 never appears.
- Signed extremes, RELU_EN=0: 2x2 window {-128,-1,-128,-128} -> -1; window {127,-128,-128,-128} -> 127; all -128 -> -128.
- Idle gaps: same frame as the column-ramp test with random 0-3 idle cycles between valid inputs -> identical output sequence; o_feature_valid one cycle after each odd/odd input; o_frame_done exactly once.
- Discard region: row 24 and col 40 driven to 127, rest 0 -> all 240 outputs are 0.
- Reset mid-frame: assert i_rst after 100 inputs, then a full column-ramp frame -> exactly 240 correct outputs and one o_frame_done; no stale output.
